// File: rtl/i2s_tx_fifo.sv
// rtl/i2s_tx_fifo.sv - I2S / left-justified serial transmitter fed by a stereo-pair FIFO
module i2s_tx_fifo #(
  parameter int WORD_LEN   = 16,
  parameter int SLOT_LEN   = 16,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                          BCLK,
  input  logic                          RST,
  input  logic                          en,
  input  logic                          mode,
  input  logic [WORD_LEN-1:0]           dataL,
  input  logic [WORD_LEN-1:0]           dataR,
  input  logic                          inValid,
  output logic                          inReady,
  input  logic                          clrUnderrun,
  output logic                          LRCLK,
  output logic                          dataOut,
  output logic                          underrun,
  output logic [$clog2(FIFO_DEPTH):0]   level
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = $clog2(2 * SLOT_LEN);
  localparam logic [CW-1:0] CNT_LAST = CW'(2 * SLOT_LEN - 1);
  localparam logic [CW-1:0] SLOT_C   = CW'(SLOT_LEN);
  localparam logic [AW:0]   FULL_LVL = (AW + 1)'(FIFO_DEPTH);

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_RUN  = 1'b1;

  logic [0:0]            state_q, state_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic [WORD_LEN-1:0]   word_l_q, word_l_d;
  logic [WORD_LEN-1:0]   word_r_q, word_r_d;
  logic                  mode_q, mode_d;
  logic                  delay_q, delay_d;
  logic                  underrun_q, underrun_d;
  logic [AW-1:0]         wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]         rd_ptr_q, rd_ptr_d;
  logic [AW:0]           level_q, level_d;
  logic [2*WORD_LEN-1:0] mem_q [FIFO_DEPTH];

  logic                  right_slot;
  logic [CW-1:0]         pos;
  logic [WORD_LEN-1:0]   cur_word;
  logic [WORD_LEN-1:0]   shifted;
  logic                  lj_bit;
  logic                  frame_end;
  logic                  pop_req;
  logic                  empty;
  logic                  full;
  logic                  push;
  logic                  pop;
  logic                  new_ur;
  logic [2*WORD_LEN-1:0] head;

  // Left-justified bit for the current slot position; zero beyond the word and while idle
  always_comb begin
    right_slot = (cnt_q >= SLOT_C);
    pos        = right_slot ? (cnt_q - SLOT_C) : cnt_q;
    cur_word   = right_slot ? word_r_q : word_l_q;
    shifted    = cur_word << pos;
    lj_bit     = (state_q == ST_RUN) & shifted[WORD_LEN-1];
  end

  // Serial outputs: I2S mode uses the one-BCLK delayed copy, LRCLK is never delayed
  always_comb begin
    LRCLK    = (state_q == ST_RUN) & right_slot;
    dataOut  = (state_q == ST_RUN) ? (mode_q ? lj_bit : delay_q) : 1'b0;
    underrun = underrun_q;
    level    = level_q;
    inReady  = ~full;
  end

  // Next-state logic: framing FSM, FIFO pointers and the sticky underrun flag
  always_comb begin
    empty     = (level_q == '0);
    full      = (level_q == FULL_LVL);
    frame_end = (state_q == ST_RUN) && (cnt_q == CNT_LAST);
    pop_req   = en && ((state_q == ST_IDLE) || frame_end);
    push      = inValid && !full;
    pop       = pop_req && !empty;
    new_ur    = pop_req && empty;
    head      = mem_q[rd_ptr_q];

    state_d   = state_q;
    cnt_d     = cnt_q;
    mode_d    = mode_q;
    word_l_d  = word_l_q;
    word_r_d  = word_r_q;
    delay_d   = lj_bit;

    if (state_q == ST_IDLE) begin
      cnt_d = '0;
      if (en) begin
        state_d = ST_RUN;
        mode_d  = mode;
      end
    end else begin
      cnt_d = frame_end ? '0 : cnt_q + 1'b1;
      if (frame_end) begin
        if (!en) state_d = ST_IDLE;
        else     mode_d  = mode;
      end
    end

    if (pop_req) begin
      word_l_d = pop ? head[2*WORD_LEN-1:WORD_LEN] : '0;
      word_r_d = pop ? head[WORD_LEN-1:0]          : '0;
    end

    wr_ptr_d   = wr_ptr_q + AW'(push);
    rd_ptr_d   = rd_ptr_q + AW'(pop);
    level_d    = level_q + (AW + 1)'(push) - (AW + 1)'(pop);
    underrun_d = new_ur ? 1'b1 : (clrUnderrun ? 1'b0 : underrun_q);
  end

  // State registers, cleared asynchronously by RST
  always_ff @(negedge BCLK or posedge RST) begin
    if (RST) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      word_l_q   <= '0;
      word_r_q   <= '0;
      mode_q     <= 1'b0;
      delay_q    <= 1'b0;
      underrun_q <= 1'b0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      level_q    <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      word_l_q   <= word_l_d;
      word_r_q   <= word_r_d;
      mode_q     <= mode_d;
      delay_q    <= delay_d;
      underrun_q <= underrun_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      level_q    <= level_d;
    end
  end

  // FIFO storage; contents are don't-care while the pointers say empty
  always_ff @(negedge BCLK) begin
    if (push) mem_q[wr_ptr_q] <= {dataL, dataR};
  end

endmodule
